// File: rtl/mips_isa_pkg.sv
// Package: mips_isa_pkg
// Shared MIPS subset definitions used by the control-unit decoder and by
// instr_encoder: mnemonic request codes, opcode/func constants, field bit
// positions, word-building helpers and the encoder FSM state type.
package mips_isa_pkg;

  // Mnemonic request codes. Codes 11..15 are illegal.
  typedef enum logic [3:0] {
    MN_NOP = 4'd0,
    MN_ADD = 4'd1,
    MN_SUB = 4'd2,
    MN_AND = 4'd3,
    MN_OR  = 4'd4,
    MN_NOR = 4'd5,
    MN_SLT = 4'd6,
    MN_LW  = 4'd7,
    MN_SW  = 4'd8,
    MN_BEQ = 4'd9,
    MN_J   = 4'd10
  } mnem_e;

  // Encoder sequencing states, kept here so checkers can decode the state.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } enc_state_e;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  localparam logic [5:0] FN_ADD = 6'd32;
  localparam logic [5:0] FN_SUB = 6'd34;
  localparam logic [5:0] FN_AND = 6'd36;
  localparam logic [5:0] FN_OR  = 6'd37;
  localparam logic [5:0] FN_NOR = 6'd39;
  localparam logic [5:0] FN_SLT = 6'd42;

  // Field least-significant bit positions within the 32-bit word.
  localparam int OP_LSB  = 26;
  localparam int RS_LSB  = 21;
  localparam int RT_LSB  = 16;
  localparam int RD_LSB  = 11;
  localparam int FN_LSB  = 0;
  localparam int IMM_LSB = 0;
  localparam int TGT_LSB = 0;

  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  // R-type: shamt is always zero for this subset.
  function automatic logic [31:0] r_word(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [5:0] fn);
    logic [31:0] w;
    w = '0;
    w[OP_LSB +: 6] = OP_RTYPE;
    w[RS_LSB +: 5] = rs;
    w[RT_LSB +: 5] = rt;
    w[RD_LSB +: 5] = rd;
    w[FN_LSB +: 6] = fn;
    return w;
  endfunction

  function automatic logic [31:0] i_word(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
    logic [31:0] w;
    w = '0;
    w[OP_LSB +: 6]   = op;
    w[RS_LSB +: 5]   = rs;
    w[RT_LSB +: 5]   = rt;
    w[IMM_LSB +: 16] = imm;
    return w;
  endfunction

  function automatic logic [31:0] j_word(input logic [5:0] op, input logic [25:0] target);
    logic [31:0] w;
    w = '0;
    w[OP_LSB +: 6]   = op;
    w[TGT_LSB +: 26] = target;
    return w;
  endfunction

endpackage

// File: rtl/instr_word_pack.sv
// Module: instr_word_pack
// Combinational packer: mnemonic code plus operand fields -> 32-bit MIPS word.
// Fields a format does not use are ignored. Illegal codes (11..15) give 0.
// Optional macro ENC_ILLEGAL_CHECK_EN adds the illegal flag output.
// Ports:
//   mnem    in  4   mnemonic code
//   rs/rt/rd in 5   register fields
//   imm     in  16  I-type immediate
//   target  in  26  J-type target
//   word    out 32  encoded word
//   illegal out 1   (ENC_ILLEGAL_CHECK_EN only) mnem is 11..15
module instr_word_pack (
  input  logic [3:0]  mnem,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [15:0] imm,
  input  logic [25:0] target,
`ifdef ENC_ILLEGAL_CHECK_EN
  output logic        illegal,
`endif
  output logic [31:0] word
);
  import mips_isa_pkg::*;

  always_comb begin
    word = NOP_WORD;
`ifdef ENC_ILLEGAL_CHECK_EN
    illegal = 1'b0;
`endif
    case (mnem)
      MN_NOP: word = NOP_WORD;
      MN_ADD: word = r_word(rs, rt, rd, FN_ADD);
      MN_SUB: word = r_word(rs, rt, rd, FN_SUB);
      MN_AND: word = r_word(rs, rt, rd, FN_AND);
      MN_OR:  word = r_word(rs, rt, rd, FN_OR);
      MN_NOR: word = r_word(rs, rt, rd, FN_NOR);
      MN_SLT: word = r_word(rs, rt, rd, FN_SLT);
      MN_LW:  word = i_word(OP_LW, rs, rt, imm);
      MN_SW:  word = i_word(OP_SW, rs, rt, imm);
      MN_BEQ: word = i_word(OP_BEQ, rs, rt, imm);
      MN_J:   word = j_word(OP_J, target);
      default: begin
        word = NOP_WORD;
`ifdef ENC_ILLEGAL_CHECK_EN
        illegal = 1'b1;
`endif
      end
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Module: instr_encoder
// Streams encoded MIPS words into instruction memory at consecutive word
// addresses starting from BASE_ADDR. A sequence begins with start, accepts one
// request per LOAD visit, writes it the following cycle, and ends after a
// request flagged in_last or after DEPTH words, with a one-cycle done pulse.
// Optional macro ENC_ILLEGAL_CHECK_EN adds the illegal output.
//
// Handshake: a request transfers on a rising edge where in_valid and
// in_ready are both high; in_ready is high only in LOAD, so at most one
// request is taken per write and the requester must hold its fields until
// that edge. The accepted word appears with imem_we high for exactly the
// next cycle.
//
// Ports:
//   clk, rst_n             clock, async active-low reset
//   start                  begin sequence (only honoured when idle)
//   in_valid / in_ready    request handshake
//   in_mnem, in_rs, in_rt, in_rd, in_imm, in_target, in_last  request
//   imem_we, imem_addr, imem_wdata   instruction-memory write port
//   busy, done, count      status: not idle, end pulse, words written
//   illegal                (ENC_ILLEGAL_CHECK_EN only) flags written word
// The FSM state is visible as the internal signal `state` (enc_state_e).
module instr_encoder #(
  parameter int ADDR_W    = 6,
  parameter int DEPTH     = 64,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_mnem,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_target,
  input  logic              in_last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              done,
`ifdef ENC_ILLEGAL_CHECK_EN
  output logic              illegal,
`endif
  output logic [ADDR_W:0]   count
);
  import mips_isa_pkg::*;

  localparam logic [ADDR_W-1:0] BASE  = BASE_ADDR[ADDR_W-1:0];
  localparam logic [ADDR_W:0]   LIMIT = DEPTH[ADDR_W:0];

  enc_state_e  state;
  logic        last_r;
  logic [31:0] word;
`ifdef ENC_ILLEGAL_CHECK_EN
  logic        word_illegal;
`endif

  instr_word_pack u_pack (
    .mnem    (in_mnem),
    .rs      (in_rs),
    .rt      (in_rt),
    .rd      (in_rd),
    .imm     (in_imm),
    .target  (in_target),
`ifdef ENC_ILLEGAL_CHECK_EN
    .illegal (word_illegal),
`endif
    .word    (word)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      in_ready   <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= BASE;
      imem_wdata <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      count      <= '0;
      last_r     <= 1'b0;
`ifdef ENC_ILLEGAL_CHECK_EN
      illegal    <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state     <= ST_LOAD;
            in_ready  <= 1'b1;
            busy      <= 1'b1;
            imem_addr <= BASE;
            count     <= '0;
          end
        end
        ST_LOAD: begin
          if (in_valid && in_ready) begin
            state      <= ST_WRITE;
            in_ready   <= 1'b0;
            imem_we    <= 1'b1;
            imem_wdata <= word;
            last_r     <= in_last;
`ifdef ENC_ILLEGAL_CHECK_EN
            illegal    <= word_illegal;
`endif
          end
        end
        ST_WRITE: begin
          imem_we   <= 1'b0;
`ifdef ENC_ILLEGAL_CHECK_EN
          illegal   <= 1'b0;
`endif
          // Address and count move on once the write has been presented;
          // the address wraps naturally at 2**ADDR_W.
          imem_addr <= imem_addr + 1'b1;
          count     <= count + 1'b1;
          // count still holds the pre-write value here, so +1 is the total.
          if (last_r || (count + 1'b1 == LIMIT)) begin
            state <= ST_DONE;
            done  <= 1'b1;
          end else begin
            state    <= ST_LOAD;
            in_ready <= 1'b1;
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Testbench for instr_encoder: three instances with different geometry
// (64-deep default, 4-deep at base 0, 4-deep at base 6 with 3-bit address
// to exercise wrap), driven one at a time, with a transaction-level model.
module tb_instr_encoder;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- shared stimulus ----------------
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic [3:0]  in_mnem = '0;
  logic [4:0]  in_rs = '0, in_rt = '0, in_rd = '0;
  logic [15:0] in_imm = '0;
  logic [25:0] in_target = '0;
  logic [1:0]  sel = 2'd0;

  logic a_start, b_start, c_start, a_valid, b_valid, c_valid;
  assign a_start = start && (sel == 2'd0);
  assign b_start = start && (sel == 2'd1);
  assign c_start = start && (sel == 2'd2);
  assign a_valid = in_valid && (sel == 2'd0);
  assign b_valid = in_valid && (sel == 2'd1);
  assign c_valid = in_valid && (sel == 2'd2);

  // ---------------- DUT outputs ----------------
  logic a_rdy, a_we, a_busy, a_done; logic [31:0] a_wd; logic [5:0] a_addr; logic [6:0] a_cnt;
  logic b_rdy, b_we, b_busy, b_done; logic [31:0] b_wd; logic [1:0] b_addr; logic [2:0] b_cnt;
  logic c_rdy, c_we, c_busy, c_done; logic [31:0] c_wd; logic [2:0] c_addr; logic [3:0] c_cnt;
`ifdef ENC_ILLEGAL_CHECK_EN
  logic a_ill, b_ill, c_ill;
`endif

  instr_encoder #(.ADDR_W(6), .DEPTH(64), .BASE_ADDR(0)) dut (
    .clk(clk), .rst_n(rst_n), .start(a_start), .in_valid(a_valid), .in_ready(a_rdy),
    .in_mnem(in_mnem), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
    .in_target(in_target), .in_last(in_last), .imem_we(a_we), .imem_addr(a_addr),
    .imem_wdata(a_wd), .busy(a_busy), .done(a_done),
`ifdef ENC_ILLEGAL_CHECK_EN
    .illegal(a_ill),
`endif
    .count(a_cnt));

  instr_encoder #(.ADDR_W(2), .DEPTH(4), .BASE_ADDR(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(b_start), .in_valid(b_valid), .in_ready(b_rdy),
    .in_mnem(in_mnem), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
    .in_target(in_target), .in_last(in_last), .imem_we(b_we), .imem_addr(b_addr),
    .imem_wdata(b_wd), .busy(b_busy), .done(b_done),
`ifdef ENC_ILLEGAL_CHECK_EN
    .illegal(b_ill),
`endif
    .count(b_cnt));

  instr_encoder #(.ADDR_W(3), .DEPTH(4), .BASE_ADDR(6)) dut_c (
    .clk(clk), .rst_n(rst_n), .start(c_start), .in_valid(c_valid), .in_ready(c_rdy),
    .in_mnem(in_mnem), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
    .in_target(in_target), .in_last(in_last), .imem_we(c_we), .imem_addr(c_addr),
    .imem_wdata(c_wd), .busy(c_busy), .done(c_done),
`ifdef ENC_ILLEGAL_CHECK_EN
    .illegal(c_ill),
`endif
    .count(c_cnt));

  // Selected-instance view.
  logic s_rdy, s_we, s_busy, s_done, s_ill;
  logic [31:0] s_wd;
  logic [5:0]  s_addr;
  logic [6:0]  s_cnt;
  always_comb begin
    s_rdy = a_rdy; s_we = a_we; s_busy = a_busy; s_done = a_done;
    s_wd = a_wd; s_addr = a_addr; s_cnt = a_cnt; s_ill = 1'b0;
`ifdef ENC_ILLEGAL_CHECK_EN
    s_ill = a_ill;
`endif
    if (sel == 2'd1) begin
      s_rdy = b_rdy; s_we = b_we; s_busy = b_busy; s_done = b_done;
      s_wd = b_wd; s_addr = {4'b0, b_addr}; s_cnt = {4'b0, b_cnt};
`ifdef ENC_ILLEGAL_CHECK_EN
      s_ill = b_ill;
`endif
    end else if (sel == 2'd2) begin
      s_rdy = c_rdy; s_we = c_we; s_busy = c_busy; s_done = c_done;
      s_wd = c_wd; s_addr = {3'b0, c_addr}; s_cnt = {3'b0, c_cnt};
`ifdef ENC_ILLEGAL_CHECK_EN
      s_ill = c_ill;
`endif
    end
  end

  // ---------------- scoreboard state ----------------
  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];
  bit          ill_q[$];
  logic [31:0] wlog_data[$];
  logic [5:0]  wlog_addr[$];
  bit          wlog_ill[$];
  int          done_cnt = 0;

  // Model of the selected instance's sequence.
  bit m_active, m_we, m_done, m_final;
  int m_nacc;
  int m_count[3];

  function automatic int p_aw();
    return (sel == 2'd0) ? 6 : (sel == 2'd1) ? 2 : 3;
  endfunction
  function automatic int p_depth();
    return (sel == 2'd0) ? 64 : 4;
  endfunction
  function automatic int p_base();
    return (sel == 2'd2) ? 6 : 0;
  endfunction

  // Reference encoding straight from the instruction formats.
  function automatic logic [31:0] ref_word(input int mn, input logic [4:0] rs, input logic [4:0] rt,
                                           input logic [4:0] rd, input logic [15:0] imm,
                                           input logic [25:0] tgt);
    logic [31:0] f;
    logic [31:0] op;
    f = 0; op = 0;
    case (mn)
      1: f = 32; 2: f = 34; 3: f = 36; 4: f = 37; 5: f = 39; 6: f = 42;
      7: op = 35; 8: op = 43; 9: op = 4;
      default: ;
    endcase
    if (mn >= 1 && mn <= 6)
      return (32'(rs) << 21) | (32'(rt) << 16) | (32'(rd) << 11) | f;
    if (mn >= 7 && mn <= 9)
      return (op << 26) | (32'(rs) << 21) | (32'(rt) << 16) | 32'(imm);
    if (mn == 10)
      return (32'd2 << 26) | 32'(tgt);
    return 32'h0;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- model + compare loop ----------------
  task automatic model_step();
    bit acc, st, n_done;
    if (!rst_n) begin
      m_active = 0; m_we = 0; m_done = 0; m_final = 0; m_nacc = 0;
      foreach (m_count[i]) m_count[i] = 0;
      exp_q.delete(); ill_q.delete();
    end else begin
      acc    = in_valid && m_active && !m_we && !m_done;
      st     = start && !m_active;
      n_done = m_we && m_final;
      if (m_we) m_count[sel]++;
      if (m_done) m_active = 0;
      if (st) begin m_active = 1; m_count[sel] = 0; m_nacc = 0; end
      if (acc) begin
        exp_q.push_back(ref_word(int'(in_mnem), in_rs, in_rt, in_rd, in_imm, in_target));
        ill_q.push_back(in_mnem >= 4'd11);
        m_final = in_last || (m_nacc + 1 == p_depth());
        m_nacc++;
      end
      m_we   = acc;
      m_done = n_done;
    end
  endtask

  task automatic compare_step();
    logic [31:0] w;
    bit il;
    if (!rst_n) begin
      chk("rst_in_ready", s_rdy, 0);
      chk("rst_imem_we", s_we, 0);
      chk("rst_busy", s_busy, 0);
      chk("rst_done", s_done, 0);
      chk("rst_imem_addr", s_addr, 64'(p_base()));
      chk("rst_imem_wdata", s_wd, 0);
      chk("rst_count", s_cnt, 0);
      chk("rst_illegal", s_ill, 0);
    end else begin
      chk("in_ready", s_rdy, m_active && !m_we && !m_done);
      chk("imem_we", s_we, m_we);
      chk("busy", s_busy, m_active);
      chk("done", s_done, m_done);
      chk("count", s_cnt, 64'(m_count[sel]));
      chk("imem_addr", s_addr, 64'((p_base() + m_count[sel]) % (1 << p_aw())));
      if (s_we) begin
        wlog_data.push_back(s_wd);
        wlog_addr.push_back(s_addr);
        wlog_ill.push_back(s_ill);
      end
      if (s_done) done_cnt++;
      if (m_we) begin
        if (exp_q.size() > 0) begin
          w = exp_q.pop_front();
          il = ill_q.pop_front();
          chk("imem_wdata", s_wd, w);
`ifdef ENC_ILLEGAL_CHECK_EN
          chk("illegal", s_ill, il);
`else
          if (il) chk("illegal_word_zero", s_wd, 0);
`endif
        end else begin
          chk("exp_q_underflow", 1, 0);
        end
      end
    end
  endtask

  task automatic monitor_loop();
    forever begin
      @(posedge clk);
      model_step();
      @(negedge clk);
      compare_step();
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send(input int mn, input logic [4:0] rs_v, input logic [4:0] rt_v,
                      input logic [4:0] rd_v, input logic [15:0] imm_v, input logic [25:0] tgt_v,
                      input bit last_v, input int budget, output bit ok);
    @(negedge clk);
    in_mnem = 4'(mn); in_rs = rs_v; in_rt = rt_v; in_rd = rd_v;
    in_imm = imm_v; in_target = tgt_v; in_last = last_v; in_valid = 1'b1;
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      if (s_rdy) begin ok = 1; break; end
    end
    #1;
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic send_rand(input int mn, input bit last_v, input int budget, output bit ok);
    send(mn, 5'($urandom), 5'($urandom), 5'($urandom), 16'($urandom), 26'($urandom),
         last_v, budget, ok);
  endtask

  task automatic wait_idle(input int budget);
    bit seen;
    seen = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #1;
      if (!s_busy) begin seen = 1; break; end
    end
    if (!seen) chk("idle_timeout", 1, 0);
  endtask

  // ---------------- tests ----------------
  task automatic run_tests();
    bit ok;
    int n0, d0, nreq;

    repeat (3) @(negedge clk);
    #1;
    chk("reset_busy", a_busy, 0);
    chk("reset_count", a_cnt, 0);
    chk("reset_wdata", a_wd, 0);
    chk("reset_ready", a_rdy, 0);
    rst_n = 1'b1;

    // Pin the reference encoder with hand-computed words.
    chk("model_add", ref_word(1, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0), 32'h00221820);
    chk("model_lw",  ref_word(7, 5'd29, 5'd8, 5'd0, 16'h4, 26'h0), 32'h8FA80004);
    chk("model_beq", ref_word(9, 5'd1, 5'd2, 5'd0, 16'hFFFF, 26'h0), 32'h1022FFFF);
    chk("model_j",   ref_word(10, 5'd0, 5'd0, 5'd0, 16'h0, 26'h10), 32'h08000010);

    // ADD, LW, BEQ(last) into the 64-deep instance.
    n0 = wlog_data.size(); d0 = done_cnt;
    do_start();
    send(1, 5'd1, 5'd2, 5'd3, 16'h1234, 26'h0, 1'b0, 6, ok);  chk("t1_acc_add", ok, 1);
    send(7, 5'd29, 5'd8, 5'd7, 16'h0004, 26'h0, 1'b0, 6, ok); chk("t1_acc_lw", ok, 1);
    send(9, 5'd1, 5'd2, 5'd9, 16'hFFFF, 26'h0, 1'b1, 6, ok);  chk("t1_acc_beq", ok, 1);
    wait_idle(20);
    chk("t1_nwrites", wlog_data.size() - n0, 3);
    chk("t1_w0", wlog_data[n0], 32'h00221820);     chk("t1_a0", wlog_addr[n0], 0);
    chk("t1_w1", wlog_data[n0+1], 32'h8FA80004);   chk("t1_a1", wlog_addr[n0+1], 1);
    chk("t1_w2", wlog_data[n0+2], 32'h1022FFFF);   chk("t1_a2", wlog_addr[n0+2], 2);
    chk("t1_done_pulses", done_cnt - d0, 1);
    chk("t1_count", a_cnt, 3);
    chk("t1_busy", a_busy, 0);

    // J alone with in_last.
    n0 = wlog_data.size(); d0 = done_cnt;
    do_start();
    send(10, 5'd3, 5'd4, 5'd5, 16'h55AA, 26'h10, 1'b1, 6, ok); chk("t2_acc_j", ok, 1);
    wait_idle(20);
    chk("t2_w0", wlog_data[n0], 32'h08000010);
    chk("t2_a0", wlog_addr[n0], 0);
    chk("t2_done_pulses", done_cnt - d0, 1);
    chk("t2_count", a_cnt, 1);
    chk("t2_busy", a_busy, 0);

    // DEPTH=4 instance, five requests without in_last.
    sel = 2'd1;
    n0 = wlog_data.size(); d0 = done_cnt;
    do_start();
    for (int k = 0; k < 4; k++) begin
      send_rand(1 + k, 1'b0, 6, ok);
      chk("t3_acc", ok, 1);
    end
    send_rand(2, 1'b0, 8, ok);
    chk("t3_fifth_refused", ok, 0);
    wait_idle(20);
    chk("t3_nwrites", wlog_data.size() - n0, 4);
    for (int k = 0; k < 4; k++) chk("t3_addr", wlog_addr[n0+k], 64'(k));
    chk("t3_done_pulses", done_cnt - d0, 1);
    chk("t3_count", b_cnt, 4);

    // Illegal mnemonic encodes as zero.
    sel = 2'd0;
    n0 = wlog_data.size();
    do_start();
    send(12, 5'd31, 5'd31, 5'd31, 16'hFFFF, 26'h3FFFFFF, 1'b1, 6, ok);
    wait_idle(20);
    chk("t4_word", wlog_data[n0], 0);
`ifdef ENC_ILLEGAL_CHECK_EN
    chk("t4_illegal", wlog_ill[n0], 1);
`endif

    // Reset asserted while a write is being presented.
    d0 = done_cnt;
    do_start();
    send_rand(1, 1'b0, 6, ok);
    send_rand(2, 1'b0, 6, ok);
    #1 rst_n = 1'b0;
    #1;
    chk("t5_we", a_we, 0);
    chk("t5_busy", a_busy, 0);
    chk("t5_addr", a_addr, 0);
    chk("t5_count", a_cnt, 0);
    chk("t5_wdata", a_wd, 0);
    chk("t5_ready", a_rdy, 0);
    @(negedge clk);
    @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("t5_no_done", done_cnt - d0, 0);
    n0 = wlog_data.size();
    do_start();
    send(4, 5'd7, 5'd8, 5'd9, 16'h0, 26'h0, 1'b1, 6, ok);
    wait_idle(20);
    chk("t5_restart_addr", wlog_addr[n0], 0);
    chk("t5_restart_word", wlog_data[n0], 32'h00E84825);

    // Randomized sequences across all three geometries.
    for (int s = 0; s < 3; s++) begin
      sel = 2'(s);
      for (int q = 0; q < 12; q++) begin
        if ($urandom_range(0, 3) == 0) begin
          // A request while idle must be ignored.
          send_rand($urandom_range(0, 15), 1'b0, 1, ok);
        end
        do_start();
        if ($urandom_range(0, 2) == 0) do_start();
        nreq = $urandom_range(1, (s == 0) ? 8 : 6);
        for (int k = 0; k < nreq; k++) begin
          repeat ($urandom_range(0, 2)) @(negedge clk);
          send_rand($urandom_range(0, 15), k == nreq - 1, 10, ok);
          if (!ok) break;
        end
        wait_idle(30);
      end
    end

    // Fill the 64-deep instance to its limit.
    sel = 2'd0;
    d0 = done_cnt;
    do_start();
    for (int k = 0; k < 66; k++) begin
      send_rand($urandom_range(0, 15), 1'b0, 8, ok);
      if (!ok) break;
    end
    wait_idle(30);
    chk("t7_count", a_cnt, 64);
    chk("t7_done_pulses", done_cnt - d0, 1);
  endtask

  initial begin
    fork
      monitor_loop();
      run_tests();
    join_any
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
